mmio_fabric: RTL and testbench

Parametrised MMIO interconnect between the core's data port and NUM_CH crypto/RAM peripherals. It decodes a contiguous array of equal-sized windows and forwards byte strobes unmodified to the selected peripheral. It tracks one outstanding transaction with a request/wait/response state machine, and answers decode misses and unresponsive slaves with an error response after a bounded timeout. It replaces the fixed five-slave combinational mux and adds address-range checking, strobe pass-through, timeout recovery and an error counter.

---
 rtl/mmio_fabric_if.sv | 44 ++++
 rtl/mmio_fabric.sv | 158 +++++++++++++++
 tb/tb_mmio_fabric.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_fabric_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmio_fabric_if: core-side MMIO bus plus shared fabric-to-peripheral bundle.
// Revision 1.0
// ----------------------------------------------------------------------------
interface mmio_fabric_if #(
  parameter int NUM_CH   = 5,
  parameter int WIN_LOG2 = 12
);
  logic                   valid;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   we;
  logic [31:0]            rdata;
  logic                   ready;
  logic                   err;

  logic [NUM_CH-1:0]      s_valid;
  logic [WIN_LOG2-1:0]    s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;
  logic                   s_we;
  logic [NUM_CH*32-1:0]   s_rdata;
  logic [NUM_CH-1:0]      s_ready;

  modport master (
    output valid, addr, wdata, wstrb, we,
    input  rdata, ready, err
  );

  modport slave (
    input  valid, addr, wdata, wstrb, we,
    output rdata, ready, err,
    output s_valid, s_addr, s_wdata, s_wstrb, s_we,
    input  s_rdata, s_ready
  );

  modport periph (
    input  s_valid, s_addr, s_wdata, s_wstrb, s_we,
    output s_rdata, s_ready
  );
endinterface
`default_nettype wire

// File: rtl/mmio_fabric.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmio_fabric: windowed MMIO interconnect with timeout and error counting.
// Revision 1.0
// ----------------------------------------------------------------------------
module mmio_fabric #(
  parameter int unsigned NUM_CH    = 5,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned WIN_LOG2  = 12,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rst,
  mmio_fabric_if.slave bus,
  output logic [15:0]  err_cnt
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IDX_W = 32 - WIN_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [IDX_W-1:0]    w_idx;
  logic                w_hit;
  logic                w_nop;
  logic                w_sel_ready;
  logic [31:0]         w_sel_rdata;
  logic                w_resp_err;
  logic [31:0]         w_resp_rdata;

  logic [CH_W-1:0]     r_ch;
  logic                r_miss;
  logic                r_nop;
  logic [15:0]         r_cnt;
  logic [NUM_CH-1:0]   r_s_valid;
  logic [WIN_LOG2-1:0] r_s_addr;
  logic [31:0]         r_s_wdata;
  logic [3:0]          r_s_wstrb;
  logic                r_s_we;
  logic                r_ready;
  logic                r_err;
  logic [31:0]         r_rdata;

  assign w_idx = bus.addr[31:WIN_LOG2] - BASE_ADDR[31:WIN_LOG2];
  assign w_hit = (bus.addr >= BASE_ADDR) && (w_idx < IDX_W'(NUM_CH));
  assign w_nop = bus.we && (bus.wstrb == 4'b0000);

  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CH_W'(i)) begin
        w_sel_ready = bus.s_ready[i];
        w_sel_rdata = bus.s_rdata[32*i +: 32];
      end
    end
  end

  // Decode outcome is registered in IDLE and resolved in REQ, so misses and
  // zero-strobe writes never raise s_valid and still respond two cycles later.
  always_comb begin
    state_nxt    = state;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    case (state)
      IDLE: begin
        if (bus.valid) state_nxt = REQ;
      end
      REQ: begin
        if (r_miss || r_nop) begin
          state_nxt    = RESP;
          w_resp_err   = r_miss;
          w_resp_rdata = r_miss ? ERR_RDATA : 32'h0;
        end else if (w_sel_ready) begin
          state_nxt    = RESP;
          w_resp_rdata = r_s_we ? 32'h0 : w_sel_rdata;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_sel_ready) begin
          state_nxt    = RESP;
          w_resp_rdata = r_s_we ? 32'h0 : w_sel_rdata;
        end else if (r_cnt == 16'(TIMEOUT)) begin
          state_nxt    = RESP;
          w_resp_err   = 1'b1;
          w_resp_rdata = ERR_RDATA;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      r_ch      <= '0;
      r_miss    <= 1'b0;
      r_nop     <= 1'b0;
      r_cnt     <= '0;
      r_s_valid <= '0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wstrb <= '0;
      r_s_we    <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      r_s_valid <= '0;
      r_ready   <= (state_nxt == RESP);
      r_err     <= w_resp_err;
      r_rdata   <= w_resp_rdata;

      if (w_resp_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;

      if ((state == IDLE) && bus.valid) begin
        r_s_addr  <= bus.addr[WIN_LOG2-1:0];
        r_s_wdata <= bus.wdata;
        r_s_wstrb <= bus.wstrb;
        r_s_we    <= bus.we;
        r_ch      <= w_idx[CH_W-1:0];
        r_miss    <= !w_hit;
        r_nop     <= w_hit && w_nop;
        if (w_hit && !w_nop) r_s_valid <= NUM_CH'(1) << w_idx[CH_W-1:0];
      end

      if (state == REQ) r_cnt <= '0;
      else if (state == WAIT) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.ready   = r_ready;
  assign bus.err     = r_err;
  assign bus.rdata   = r_rdata;
  assign bus.s_valid = r_s_valid;
  assign bus.s_addr  = r_s_addr;
  assign bus.s_wdata = r_s_wdata;
  assign bus.s_wstrb = r_s_wstrb;
  assign bus.s_we    = r_s_we;
endmodule
`default_nettype wire

// File: tb/tb_mmio_fabric.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mmio_fabric: directed and randomized checks of mmio_fabric against a
// window-decode / latency reference model.
// ----------------------------------------------------------------------------
module tb_mmio_fabric;
  localparam int          NUM_CH   = 5;
  localparam logic [31:0] BASE     = 32'h4000_0000;
  localparam int          WIN_LOG2 = 12;
  localparam int          WIN      = 4096;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] ERR      = 32'hDEAD_BEEF;
  localparam int          NEVER    = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] err_cnt;
  logic [15:0] errc = 16'h0;
  int          n_cmp = 0;
  int          n_fail = 0;

  mmio_fabric_if #(.NUM_CH(NUM_CH), .WIN_LOG2(WIN_LOG2)) bus ();

  mmio_fabric #(
    .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .WIN_LOG2(WIN_LOG2),
    .TIMEOUT(TIMEOUT), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ready"},   32'(bus.ready),   32'h0);
    chk({tag, ".err"},     32'(bus.err),     32'h0);
    chk({tag, ".rdata"},   bus.rdata,        32'h0);
    chk({tag, ".s_valid"}, 32'(bus.s_valid), 32'h0);
    chk({tag, ".s_addr"},  32'(bus.s_addr),  32'h0);
    chk({tag, ".s_wdata"}, bus.s_wdata,      32'h0);
    chk({tag, ".s_wstrb"}, 32'(bus.s_wstrb), 32'h0);
    chk({tag, ".s_we"},    32'(bus.s_we),    32'h0);
    chk({tag, ".err_cnt"}, 32'(err_cnt),     32'h0);
  endtask

  // One master transaction; the selected slave raises s_ready dly cycles after
  // s_valid (dly=0 means in the s_valid cycle itself). Other channels see noise.
  task automatic run_txn(input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st,
                         input int dly, input logic [31:0] sd);
    logic [31:0]          off;
    int                   ch;
    int                   exp_lat;
    int                   lat;
    int                   sv_cnt;
    bit                   hit;
    bit                   access;
    logic                 exp_err;
    logic [31:0]          exp_rd;
    logic [NUM_CH-1:0]    onehot;
    logic [NUM_CH-1:0]    exp_sv;
    logic [NUM_CH-1:0]    rdy;
    logic [NUM_CH-1:0]    sv_seen;
    logic [NUM_CH*32-1:0] rd;

    off    = a - BASE;
    hit    = (a >= BASE) && ((off / WIN) < NUM_CH);
    ch     = hit ? int'(off / WIN) : 0;
    access = hit && !(w && (st == 4'b0000));
    onehot = '0;
    onehot[ch] = 1'b1;
    exp_sv = access ? onehot : '0;

    if (!access) begin
      exp_lat = 2;
      exp_err = !hit;
      exp_rd  = hit ? 32'h0 : ERR;
    end else if (1 + dly <= TIMEOUT + 2) begin
      exp_lat = (dly == 0) ? 2 : dly + 2;
      exp_err = 1'b0;
      exp_rd  = w ? 32'h0 : sd;
    end else begin
      exp_lat = TIMEOUT + 3;
      exp_err = 1'b1;
      exp_rd  = ERR;
    end
    if (exp_err && (errc != 16'hFFFF)) errc = errc + 16'd1;

    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = a;
    bus.wdata = wd;
    bus.wstrb = st;
    bus.we    = w;
    lat = -1;
    sv_cnt = 0;
    sv_seen = '0;
    for (int c = 1; c <= TIMEOUT + 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.s_valid != '0) begin
        sv_cnt++;
        sv_seen = sv_seen | bus.s_valid;
      end
      if (c == 1) chk({tag, ".s_valid"}, 32'(bus.s_valid), 32'(exp_sv));
      if (bus.ready) begin
        lat = c;
        break;
      end
      if (access) begin
        chk({tag, ".s_addr"},  32'(bus.s_addr),  32'(a[WIN_LOG2-1:0]));
        chk({tag, ".s_wdata"}, bus.s_wdata,      wd);
        chk({tag, ".s_wstrb"}, 32'(bus.s_wstrb), 32'(st));
        chk({tag, ".s_we"},    32'(bus.s_we),    32'(w));
      end
      rdy = NUM_CH'($urandom);
      if (access) begin
        rdy = rdy & ~onehot;
        if (c == 1 + dly) rdy = rdy | onehot;
      end
      for (int i = 0; i < NUM_CH; i++) rd[32*i +: 32] = $urandom;
      rd[32*ch +: 32] = sd;
      bus.s_ready = rdy;
      bus.s_rdata = rd;
    end
    chk({tag, ".latency"}, lat,             exp_lat);
    chk({tag, ".err"},     32'(bus.err),    32'(exp_err));
    chk({tag, ".rdata"},   bus.rdata,       exp_rd);
    bus.valid   = 1'b0;
    bus.s_ready = '0;
    @(posedge clk);
    #1;
    chk({tag, ".pulse"},   32'(bus.ready),  32'h0);
    chk({tag, ".err_cnt"}, 32'(err_cnt),    32'(errc));
    chk({tag, ".sv_cnt"},  sv_cnt,          access ? 1 : 0);
    chk({tag, ".sv_seen"}, 32'(sv_seen),    32'(exp_sv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          k;
    int          r;
    int          dly;

    bus.valid   = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.we      = 1'b0;
    bus.s_ready = '0;
    bus.s_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    run_txn("read_hit",  32'h4000_4010, 1'b0, 32'h0,         4'hF,    1, 32'h1234_5678);
    run_txn("write_strb",32'h4000_1004, 1'b1, 32'hAABB_CCDD, 4'b1010, 1, 32'h5555_AAAA);
    run_txn("miss_high", 32'h4000_5000, 1'b0, 32'h0,         4'hF,    1, 32'h0);
    run_txn("miss_low",  32'h3FFF_FFFC, 1'b1, 32'h1,         4'hF,    1, 32'h0);
    chk("miss.err_cnt", 32'(err_cnt), 32'd2);
    run_txn("timeout",   32'h4000_2000, 1'b0, 32'h0,         4'hF,    NEVER, 32'hCAFE_0002);

    bus.s_ready = 5'b00100;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("late.ready", 32'(bus.ready), 32'h0);
    end
    chk("late.err_cnt", 32'(err_cnt), 32'(errc));
    bus.s_ready = '0;

    run_txn("zero_strb", 32'h4000_3008, 1'b1, 32'h7777_8888, 4'b0000, 1, 32'h0);
    run_txn("req_ready", 32'h4000_0100, 1'b0, 32'h0,         4'hF,    0, 32'h0BAD_F00D);
    run_txn("last_wait", 32'h4000_3FFC, 1'b0, 32'h0,         4'hF,    TIMEOUT + 1, 32'h600D_D00D);
    run_txn("top_window",32'h4000_4FFF, 1'b0, 32'h0,         4'hF,    3, 32'h0F0F_0F0F);

    // Abort a transaction while it sits in WAIT.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.addr  = 32'h4000_0ABC;
    bus.wdata = 32'h1357_9BDF;
    bus.wstrb = 4'hF;
    bus.we    = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_wait");
    bus.valid = 1'b0;
    @(negedge clk);
    rst  = 1'b1;
    errc = 16'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_wait.no_ready", 32'(bus.ready), 32'h0);
    end
    run_txn("after_rst", 32'h4000_0ABC, 1'b0, 32'h0, 4'hF, 2, 32'h2468_ACE0);

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      if (k < NUM_CH)       a = BASE + 32'(k) * 32'(WIN) + 32'($urandom_range(0, WIN - 1));
      else if (k == NUM_CH) a = BASE + 32'(NUM_CH) * 32'(WIN) + 32'($urandom_range(0, WIN - 1));
      else if (k == 6)      a = 32'($urandom_range(0, 32'h3FFF_FFFF));
      else                  a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      dly = 0;
      else if (r < 7)  dly = $urandom_range(1, 4);
      else if (r < 9)  dly = $urandom_range(5, 20);
      else             dly = NEVER;
      run_txn("random", a, 1'($urandom), $urandom, 4'($urandom_range(0, 15)), dly, $urandom);
    end

    // Preload the error counter so saturation is reachable within a short run.
    @(negedge clk);
    force dut.err_cnt = 16'hFFFA;
    #1;
    release dut.err_cnt;
    errc = 16'hFFFA;
    for (int n = 0; n < 8; n++) begin
      run_txn("saturate", 32'h5000_0000 + 32'(n), 1'b0, 32'h0, 4'hF, 1, 32'h0);
    end
    chk("saturate.final", 32'(err_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
